// File: rtl/sprite_pos_ctrl.sv
// sprite_pos_ctrl: bus-mapped sprite position scheduler for the LCD pixel mux.
// Shadow registers are loaded over the bus. They are committed to the active outputs
// only on the frame tick, so the picture never tears. Bounce mode steps the
// position once per frame and reflects it at the screen edges.
// Optional feature macro: SPRITE_POS_CTRL_FRAME_CNT_EN adds a 16-bit frame counter,
// which reads back in STATUS[31:16].
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no commit outstanding; outputs follow bounce or hold
//   ST_PENDING | commit requested; the next tick loads the shadows into the outputs
module sprite_pos_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'hf800_2000,
    parameter int          SCREEN_W  = 320,
    parameter int          SCREEN_H  = 480,
    parameter int          SPRITE_W  = 128,
    parameter int          SPRITE_H  = 128
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        clk_en_12_5mhz,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_wen,
    input  logic        bus_ren,
    output logic [31:0] bus_rdata,
    output logic [8:0]  sprite_x,
    output logic [8:0]  sprite_y,
    output logic        sprite_en
);

    localparam logic [8:0] XMAX = 9'(SCREEN_W - SPRITE_W);
    localparam logic [8:0] YMAX = 9'(SCREEN_H - SPRITE_H);

    typedef enum logic {ST_IDLE, ST_PENDING} commit_state_t;

    commit_state_t state_q, state_d;

    logic        ctrl_en_q, ctrl_en_d, ctrl_mode_q, ctrl_mode_d;
    logic [8:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [3:0]  step_dx_q, step_dx_d, step_dy_q, step_dy_d;
    logic        dir_x_neg_q, dir_x_neg_d, dir_y_neg_q, dir_y_neg_d;
    logic [8:0]  sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
    logic        sprite_en_q, sprite_en_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] frame_cnt;

    logic tick, hit, wr_ctrl, wr_pos, wr_step, commit_wr, apply;
    logic [9:0] step_x, step_y;
    logic unused_ok;

    // Bit 9 of the result is the new direction (1 = negative) and bits 8:0 are the new position.
    function automatic logic [9:0] step_axis(input logic [8:0] pos, input logic [3:0] d,
                                             input logic neg, input logic [8:0] max);
        logic [9:0] sum;
        logic [9:0] res;
        sum = {1'b0, pos} + {6'd0, d};
        res = {neg, pos};
        if (d != 4'd0) begin
            if (!neg) begin
                if (sum >= {1'b0, max}) res = {1'b1, max};
                else                    res = {1'b0, sum[8:0]};
            end else begin
                if (pos <= {5'd0, d}) res = {1'b0, 9'd0};
                else                  res = {1'b1, pos - {5'd0, d}};
            end
        end
        return res;
    endfunction

    function automatic logic [8:0] clamp(input logic [8:0] v, input logic [8:0] max);
        return (v > max) ? max : v;
    endfunction

    assign tick      = clk_en_12_5mhz && (hpos == 10'd0) && (vpos == 10'd0);
    assign hit       = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl   = bus_wen && hit && (bus_addr[3:2] == 2'd0);
    assign wr_pos    = bus_wen && hit && (bus_addr[3:2] == 2'd1);
    assign wr_step   = bus_wen && hit && (bus_addr[3:2] == 2'd2);
    assign commit_wr = wr_ctrl && bus_wdata[2];
    assign unused_ok = &{1'b0, bus_ren, bus_addr[1:0], bus_wdata};

    // Commit FSM next state; a commit that lands on the applying tick stays queued for the next frame.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_wr) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (tick) begin
                    apply   = 1'b1;
                    state_d = commit_wr ? ST_PENDING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file writes, commit application and bounce stepping.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        step_dx_d   = step_dx_q;
        step_dy_d   = step_dy_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;
        sprite_x_d  = sprite_x_q;
        sprite_y_d  = sprite_y_q;
        sprite_en_d = sprite_en_q;
        step_x      = step_axis(sprite_x_q, step_dx_q, dir_x_neg_q, XMAX);
        step_y      = step_axis(sprite_y_q, step_dy_q, dir_y_neg_q, YMAX);

        if (wr_ctrl) begin
            ctrl_en_d   = bus_wdata[0];
            ctrl_mode_d = bus_wdata[1];
        end
        if (wr_pos) begin
            pos_x_d = bus_wdata[8:0];
            pos_y_d = bus_wdata[24:16];
        end
        if (wr_step) begin
            step_dx_d = bus_wdata[3:0];
            step_dy_d = bus_wdata[19:16];
        end

        if (apply) begin
            sprite_en_d = ctrl_en_q;
            sprite_x_d  = clamp(pos_x_q, XMAX);
            sprite_y_d  = clamp(pos_y_q, YMAX);
            dir_x_neg_d = 1'b0;
            dir_y_neg_d = 1'b0;
        end else if (tick && ctrl_en_q && ctrl_mode_q) begin
            {dir_x_neg_d, sprite_x_d} = step_x;
            {dir_y_neg_d, sprite_y_d} = step_y;
        end
    end

    // Read decode; registered into bus_rdata on the next edge.
    always_comb begin
        rdata_d = 32'd0;
        if (hit) begin
            case (bus_addr[3:2])
                2'd0:    rdata_d = {30'd0, ctrl_mode_q, ctrl_en_q};
                2'd1:    rdata_d = {7'd0, pos_y_q, 7'd0, pos_x_q};
                2'd2:    rdata_d = {12'd0, step_dy_q, 12'd0, step_dx_q};
                default: rdata_d = {frame_cnt, 13'd0, dir_y_neg_q, dir_x_neg_q,
                                    state_q == ST_PENDING};
            endcase
        end
    end

`ifdef SPRITE_POS_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter advances on every tick and wraps.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (tick) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    // Frame counter register.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) frame_cnt_q <= 16'd0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 1'b0;
            pos_x_q     <= 9'd0;
            pos_y_q     <= 9'd0;
            step_dx_q   <= 4'd0;
            step_dy_q   <= 4'd0;
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
            sprite_x_q  <= 9'd0;
            sprite_y_q  <= 9'd0;
            sprite_en_q <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            step_dx_q   <= step_dx_d;
            step_dy_q   <= step_dy_d;
            dir_x_neg_q <= dir_x_neg_d;
            dir_y_neg_q <= dir_y_neg_d;
            sprite_x_q  <= sprite_x_d;
            sprite_y_q  <= sprite_y_d;
            sprite_en_q <= sprite_en_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign sprite_x  = sprite_x_q;
    assign sprite_y  = sprite_y_q;
    assign sprite_en = sprite_en_q;

endmodule
